// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // RV32I load/store width encodings (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Latency counter width; covers LATENCY up to 15
    localparam int unsigned CNT_W = 4;

    // True for the zero-extending load encodings, which have no store form
    function automatic logic is_unsigned_load(input logic [2:0] funct3);
        return (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and data replication,
// load lane extraction with sign/zero extension, and access-fault detection.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Decode width, steer lanes and flag malformed accesses
    always_comb begin
        byte_en   = '0;
        wdata_rep = '0;
        load_data = '0;
        misalign  = 1'b0;
        illegal   = 1'b0;
        sel_byte  = rd_word[{addr_lo, 3'b000} +: 8];
        sel_half  = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

        case (funct3)
            F3_B, F3_BU: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                load_data = (funct3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte}
                                             : {24'b0, sel_byte};
            end
            F3_H, F3_HU: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                load_data = (funct3 == F3_H) ? {{16{sel_half[15]}}, sel_half}
                                             : {16'b0, sel_half};
                misalign  = addr_lo[0];
            end
            F3_W: begin
                byte_en   = '1;
                wdata_rep = wdata;
                load_data = rd_word;
                misalign  = (addr_lo != 2'b00);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        if (write && is_unsigned_load(funct3)) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// latency, performs the access on entry to RESP and holds the response
// until the consumer takes it. All outputs come straight from flops.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    // Storage (not cleared by reset)
    logic [31:0] mem_q [DEPTH_WORDS];

    // FSM, counter and request latch
    state_e           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             lat_write_q,  lat_write_d;
    logic [31:0]      lat_addr_q,   lat_addr_d;
    logic [31:0]      lat_wdata_q,  lat_wdata_d;
    logic [2:0]       lat_funct3_q, lat_funct3_d;

    // Registered outputs
    logic             req_ready_q,  req_ready_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic [31:0]      rsp_rdata_q,  rsp_rdata_d;
    logic             rsp_err_q,    rsp_err_d;
    logic             busy_q,       busy_d;

    // Access-path signals
    logic             acc_write;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [2:0]       acc_funct3;
    logic [IDX_W-1:0] acc_idx;
    logic             range_err;
    logic             acc_err;
    logic [31:0]      rd_word;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_rep;
    logic [31:0]      load_data;
    logic             misalign;
    logic             illegal;
    logic             enter_resp;
    logic             mem_we;

    // With LATENCY=1 the access happens on the accept edge itself, so the
    // access path takes the live request in IDLE and the latch otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_write  = req_write;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
            acc_funct3 = req_funct3;
        end else begin
            acc_write  = lat_write_q;
            acc_addr   = lat_addr_q;
            acc_wdata  = lat_wdata_q;
            acc_funct3 = lat_funct3_q;
        end
        acc_idx   = acc_addr[IDX_W+1:2];
        range_err = (acc_addr[31:2] >= 30'(DEPTH_WORDS));
        rd_word   = range_err ? '0 : mem_q[acc_idx];
        acc_err   = range_err | misalign | illegal;
    end

    dmem_lane_align u_align (
        .funct3    (acc_funct3),
        .addr_lo   (acc_addr[1:0]),
        .write     (acc_write),
        .wdata     (acc_wdata),
        .rd_word   (rd_word),
        .byte_en   (byte_en),
        .wdata_rep (wdata_rep),
        .load_data (load_data),
        .misalign  (misalign),
        .illegal   (illegal)
    );

    // Next-state, latch, counter and response computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_write_d  = lat_write_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        lat_funct3_d = lat_funct3_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        enter_resp   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    lat_write_d  = req_write;
                    lat_addr_d   = req_addr;
                    lat_wdata_d  = req_wdata;
                    lat_funct3_d = req_funct3;
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc_write) ? '0 : load_data;
        end

        mem_we      = enter_resp && acc_write && !acc_err;
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    // FSM and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            lat_write_q  <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            lat_funct3_q <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_write_q  <= lat_write_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            lat_funct3_q <= lat_funct3_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    // Byte-lane store commit; reset suppresses a pending write
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, 1024 words).
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Issue one request from IDLE, wait for the response, capture it and
    // complete the handshake (rsp_ready assumed high). Returns the cycle
    // index, counting the request-presentation cycle as 0, where rsp_valid
    // was first seen.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, output logic [31:0] rd,
                          output logic e, output int cyc);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = wd;
        req_funct3 = f3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        rd = rsp_rdata;
        e  = rsp_err;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout addr=%h got rsp_valid=%b want 1", a, rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; int cyc;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, e, cyc);
        checks++; if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_rsp got err=%b data=%h want err=0 data=0", e, rd); end
        checks++; if (cyc != 2) begin errors++; $display("FAIL sw_latency got=%0d want=2", cyc); end
        do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, e, cyc);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h want=deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err got=%b want=0", e); end
        checks++; if (cyc != 2) begin errors++; $display("FAIL lw_latency got=%0d want=2", cyc); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic e; int cyc;
        do_req(1'b1, 32'h20, 32'h11223344, 3'b010, rd, e, cyc);
        do_req(1'b1, 32'h21, 32'hFFFFFF80, 3'b000, rd, e, cyc);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL sb_err got=%b want=0", e); end
        do_req(1'b0, 32'h21, 32'h0, 3'b000, rd, e, cyc);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got=%h want=ffffff80", rd); end
        do_req(1'b0, 32'h21, 32'h0, 3'b100, rd, e, cyc);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_data got=%h want=00000080", rd); end
        do_req(1'b0, 32'h20, 32'h0, 3'b010, rd, e, cyc);
        checks++; if (rd !== 32'h11228044) begin errors++; $display("FAIL sb_word got=%h want=11228044", rd); end
        do_req(1'b0, 32'h23, 32'h0, 3'b100, rd, e, cyc);
        checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL lbu_lane3 got=%h want=00000011", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic e; int cyc;
        do_req(1'b1, 32'h30, 32'h55667788, 3'b010, rd, e, cyc);
        do_req(1'b1, 32'h32, 32'hABCD8001, 3'b001, rd, e, cyc);
        do_req(1'b0, 32'h32, 32'h0, 3'b001, rd, e, cyc);
        checks++; if (rd !== 32'hFFFF8001 || e !== 1'b0) begin errors++; $display("FAIL lh_data got=%h err=%b want=ffff8001 err=0", rd, e); end
        do_req(1'b0, 32'h32, 32'h0, 3'b101, rd, e, cyc);
        checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_data got=%h want=00008001", rd); end
        do_req(1'b0, 32'h30, 32'h0, 3'b010, rd, e, cyc);
        checks++; if (rd !== 32'h80017788) begin errors++; $display("FAIL sh_word got=%h want=80017788", rd); end
        do_req(1'b0, 32'h30, 32'h0, 3'b001, rd, e, cyc);
        checks++; if (rd !== 32'h00007788) begin errors++; $display("FAIL lh_low got=%h want=00007788", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int cyc;
        do_req(1'b0, 32'h13, 32'h0, 3'b010, rd, e, cyc);
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misalign got err=%b data=%h want err=1 data=0", e, rd); end
        do_req(1'b0, 32'h12, 32'h0, 3'b010, rd, e, cyc);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL lw_addr1 got err=%b want=1", e); end
        do_req(1'b1, 32'h0, 32'hCAFEF00D, 3'b010, rd, e, cyc);
        do_req(1'b1, DEPTH * 4, 32'h11111111, 3'b010, rd, e, cyc);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL sw_range got err=%b want=1", e); end
        do_req(1'b0, 32'h0, 32'h0, 3'b010, rd, e, cyc);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL range_nowrite got=%h want=cafef00d", rd); end
        do_req(1'b0, 32'h10, 32'h0, 3'b011, rd, e, cyc);
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL f3_011 got err=%b data=%h want err=1 data=0", e, rd); end
        do_req(1'b1, 32'h30, 32'h0, 3'b100, rd, e, cyc);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL store_bu got err=%b want=1", e); end
        do_req(1'b1, 32'h31, 32'h0000FFFF, 3'b001, rd, e, cyc);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL sh_misalign got err=%b want=1", e); end
        do_req(1'b0, 32'h30, 32'h0, 3'b010, rd, e, cyc);
        checks++; if (rd !== 32'h80017788) begin errors++; $display("FAIL err_nowrite got=%h want=80017788", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic e; int cyc;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
        @(posedge clk); #1;
        // A competing store held during WAIT/RESP must be ignored
        req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'b010;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 64) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc != 2) begin errors++; $display("FAIL bp_latency got=%0d want=2", cyc); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 ||
                busy !== 1'b1 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h e=%b busy=%b rdy=%b want v=1 d=deadbeef e=0 busy=1 rdy=0",
                         i, rsp_valid, rsp_rdata, rsp_err, busy, req_ready);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy=%b v=%b busy=%b want rdy=1 v=0 busy=0", req_ready, rsp_valid, busy);
        end
        do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, e, cyc);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_ignored_store got=%h want=deadbeef", rd); end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd; logic e; int cyc;
        do_req(1'b1, 32'h40, 32'h0BADC0DE, 3'b010, rd, e, cyc);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678; req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy got=%b want=1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rw_outputs got rdy=%b busy=%b v=%b d=%h e=%b want 1 0 0 0 0", req_ready, busy, rsp_valid, rsp_rdata, rsp_err);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        do_req(1'b0, 32'h40, 32'h0, 3'b010, rd, e, cyc);
        checks++; if (rd !== 32'h0BADC0DE) begin errors++; $display("FAIL rw_dropped got=%h want=0badc0de", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e; int cyc;
        do_req(1'b1, 32'h50, 32'hA5A55A5A, 3'b010, rd, e, cyc);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b want=1", req_ready); end
        do_req(1'b0, 32'h50, 32'h0, 3'b010, rd, e, cyc);
        checks++; if (rd !== 32'hA5A55A5A) begin errors++; $display("FAIL b2b_raw got=%h want=a5a55a5a", rd); end
        do_req(1'b1, 32'h53, 32'h0000007F, 3'b000, rd, e, cyc);
        do_req(1'b0, 32'h50, 32'h0, 3'b010, rd, e, cyc);
        checks++; if (rd !== 32'h7FA55A5A) begin errors++; $display("FAIL b2b_sb got=%h want=7fa55a5a", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
